// File: rtl/latent_pair_collector.sv
// Pairs mu/var dot-product results, buffers mu+var sums in a FWFT FIFO,
// streams them out over valid/ready and flags each completed latent frame.
module latent_pair_collector #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned LATENT_N = 42,
   parameter bit          SAT      = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       done,
   input  logic [DATA_W-1:0]          result,
   input  logic                       op_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       frame_done,
   output logic                       seq_err,
   output logic                       overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned FRM_W = (LATENT_N > 1) ? $clog2(LATENT_N) : 1;

   typedef enum logic {
      IDLE    = 1'b0,
      HAVE_MU = 1'b1
   } state_t;

   state_t              state;
   logic                done_q;
   logic [DATA_W-1:0]   mu_reg;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [FRM_W-1:0]    frame_cnt;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                capture_c;
   logic                pair_done_c;
   logic                pop_c;
   logic                push_ok_c;
   logic [DATA_W-1:0]   wrap_sum_c;
   logic [DATA_W-1:0]   sum_c;
   logic                pos_ovf_c;
   logic                neg_ovf_c;
   logic [CNT_W-1:0]    count_next_c;
   logic [PTR_W-1:0]    rd_ptr_next_c;
   logic [DATA_W-1:0]   head_next_c;

   // Capture detection, sum formation and FIFO next-state bookkeeping
   always_comb begin
      capture_c     = done_q & ~done;
      pair_done_c   = capture_c & (state == HAVE_MU) & op_mode;
      pop_c         = out_valid & out_ready;
      // A push into a full FIFO is still accepted when the head leaves this cycle
      push_ok_c     = pair_done_c & (~full | pop_c);

      wrap_sum_c    = mu_reg + result;
      pos_ovf_c     = ~mu_reg[DATA_W-1] & ~result[DATA_W-1] &  wrap_sum_c[DATA_W-1];
      neg_ovf_c     =  mu_reg[DATA_W-1] &  result[DATA_W-1] & ~wrap_sum_c[DATA_W-1];
      sum_c         = wrap_sum_c;
      if (SAT) begin
         if (pos_ovf_c)
            sum_c = {1'b0, {(DATA_W-1){1'b1}}};
         else if (neg_ovf_c)
            sum_c = {1'b1, {(DATA_W-1){1'b0}}};
      end

      count_next_c  = CNT_W'(count + CNT_W'(push_ok_c) - CNT_W'(pop_c));
      rd_ptr_next_c = pop_c ? PTR_W'(rd_ptr + PTR_W'(1)) : rd_ptr;
      // If the new head is the entry being written now, bypass the memory
      head_next_c   = (push_ok_c && (count == CNT_W'(pop_c))) ? sum_c : mem[rd_ptr_next_c];
   end

   // FIFO storage: written on every accepted push
   always_ff @(posedge clk) begin
      if (rst_n && !clr && push_ok_c)
         mem[wr_ptr] <= sum_c;
   end

   // Pairing FSM, FIFO pointers/occupancy, frame counter and sticky flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done_q     <= 1'b0;
         state      <= IDLE;
         mu_reg     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         frame_cnt  <= '0;
         count      <= '0;
         full       <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         frame_done <= 1'b0;
         seq_err    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         done_q     <= done;
         frame_done <= 1'b0;
         if (clr) begin
            state     <= IDLE;
            mu_reg    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            count     <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            seq_err   <= 1'b0;
            overflow  <= 1'b0;
         end else begin
            if (capture_c) begin
               case (state)
                  IDLE: begin
                     if (!op_mode) begin
                        mu_reg <= result;
                        state  <= HAVE_MU;
                     end else begin
                        seq_err <= 1'b1;
                     end
                  end
                  HAVE_MU: begin
                     if (!op_mode) begin
                        mu_reg  <= result;
                        seq_err <= 1'b1;
                     end else begin
                        state <= IDLE;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end

            // Frame counter follows pairings even when the push is dropped
            if (pair_done_c) begin
               if (frame_cnt == FRM_W'(LATENT_N - 1)) begin
                  frame_cnt  <= '0;
                  frame_done <= 1'b1;
               end else begin
                  frame_cnt <= FRM_W'(frame_cnt + FRM_W'(1));
               end
               if (!push_ok_c)
                  overflow <= 1'b1;
            end

            if (push_ok_c)
               wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            rd_ptr    <= rd_ptr_next_c;
            count     <= count_next_c;
            full      <= (count_next_c == CNT_W'(DEPTH));
            out_valid <= (count_next_c != '0);
            if (count_next_c != '0)
               out_data <= head_next_c;
         end
      end
   end

endmodule

// File: tb/tb_latent_pair_collector.sv
// Directed bench for latent_pair_collector: one wrapping and one saturating
// instance share stimulus; a per-cycle queue model predicts every output.
module tb_latent_pair_collector;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned DEPTH    = 64;
   localparam int unsigned LATENT_N = 42;
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr;
   logic              done;
   logic [DATA_W-1:0] result;
   logic              op_mode;
   logic              out_ready;

   logic              ov0, ov1, full0, full1, fd0, fd1, se0, se1, of0, of1;
   logic [DATA_W-1:0] od0, od1;
   logic [CNT_W-1:0]  cnt0, cnt1;

   int n_cmp = 0;
   int n_err = 0;

   // model state
   logic [DATA_W-1:0] q0[$];
   logic [DATA_W-1:0] q1[$];
   bit                m_have;
   logic [DATA_W-1:0] m_mu;
   bit                m_seq;
   bit                m_ovf;
   bit                m_fd;
   int                m_frame;
   bit                prev_done;
   int                fd_seen;

   always #5 clk = ~clk;

   latent_pair_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LATENT_N(LATENT_N), .SAT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .done(done), .result(result), .op_mode(op_mode),
      .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .count(cnt0), .full(full0),
      .frame_done(fd0), .seq_err(se0), .overflow(of0));

   latent_pair_collector #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LATENT_N(LATENT_N), .SAT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .done(done), .result(result), .op_mode(op_mode),
      .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .count(cnt1), .full(full1),
      .frame_done(fd1), .seq_err(se1), .overflow(of1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_sum(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b, input bit sat);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (sat) begin
         if (s > 32767)  s = 32767;
         if (s < -32768) s = -32768;
         return DATA_W'(s);
      end
      return DATA_W'(int'(a) + int'(b));
   endfunction

   task automatic model_clear();
      q0.delete(); q1.delete();
      m_have = 0; m_mu = '0; m_seq = 0; m_ovf = 0; m_frame = 0;
   endtask

   // One clock: check outputs against the model at the negedge, advance the
   // model with the inputs currently driven, then move to the next negedge.
   task automatic cycle();
      int  pre;
      bit  pop_now;
      chk("valid0", 32'(ov0),   32'(q0.size() != 0));
      chk("valid1", 32'(ov1),   32'(q1.size() != 0));
      chk("count0", 32'(cnt0),  32'(q0.size()));
      chk("count1", 32'(cnt1),  32'(q1.size()));
      chk("full0",  32'(full0), 32'(q0.size() == DEPTH));
      chk("seq0",   32'(se0),   32'(m_seq));
      chk("seq1",   32'(se1),   32'(m_seq));
      chk("ovf0",   32'(of0),   32'(m_ovf));
      chk("ovf1",   32'(of1),   32'(m_ovf));
      chk("fdone0", 32'(fd0),   32'(m_fd));
      chk("fdone1", 32'(fd1),   32'(m_fd));
      if (fd0) fd_seen++;
      m_fd = 0;
      if (!rst_n) begin
         model_clear();
         prev_done = 0;
      end else if (clr) begin
         model_clear();
         prev_done = done;
      end else begin
         pre     = q0.size();
         pop_now = (pre > 0) && out_ready;
         if (pop_now) begin
            chk("data0", 32'(od0), 32'(q0.pop_front()));
            chk("data1", 32'(od1), 32'(q1.pop_front()));
         end
         if (prev_done && !done) begin
            if (!op_mode) begin
               if (m_have) m_seq = 1;
               m_have = 1;
               m_mu   = result;
            end else if (!m_have) begin
               m_seq = 1;
            end else begin
               m_have = 0;
               if (pre >= DEPTH && !pop_now) m_ovf = 1;
               else begin
                  q0.push_back(ref_sum(m_mu, result, 1'b0));
                  q1.push_back(ref_sum(m_mu, result, 1'b1));
               end
               if (m_frame == LATENT_N - 1) begin
                  m_frame = 0;
                  m_fd    = 1;
               end else m_frame++;
            end
         end
         prev_done = done;
      end
      @(negedge clk);
   endtask

   task automatic capture(input logic [DATA_W-1:0] val, input logic mode, input int hold);
      done = 1'b1;
      repeat (hold) cycle();
      done    = 1'b0;
      result  = val;
      op_mode = mode;
      cycle();
   endtask

   task automatic pair(input logic [DATA_W-1:0] mu, input logic [DATA_W-1:0] vr);
      capture(mu, 1'b0, 1);
      capture(vr, 1'b1, 1);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cycle();
      clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; done = 1'b0; result = '0; op_mode = 1'b0; out_ready = 1'b0;
      model_clear();
      m_fd = 0; prev_done = 0; fd_seen = 0;
      repeat (2) @(negedge clk);
      cycle();
      chk("rst_data0", 32'(od0), 32'h0);
      chk("rst_data1", 32'(od1), 32'h0);
      rst_n = 1'b1;
      cycle();

      // basic pair, done held high for several cycles
      out_ready = 1'b1;
      capture(16'h0010, 1'b0, 4);
      capture(16'h0020, 1'b1, 1);
      repeat (3) cycle();

      // wrap / saturation
      pair(16'hFFFF, 16'h0002);
      pair(16'h7FFF, 16'h0001);
      pair(16'h8000, 16'hFFFF);
      repeat (3) cycle();

      // sequence errors
      capture(16'h0001, 1'b1, 1);
      cycle();
      chk("var_first_seq", 32'(se0), 32'h1);
      capture(16'h0005, 1'b0, 1);
      capture(16'h0007, 1'b0, 1);
      capture(16'h0001, 1'b1, 1);
      repeat (3) cycle();

      // backpressure: DEPTH+1 pairs with consumer stalled
      do_clr();
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) pair(DATA_W'(i * 3), 16'h0001);
      repeat (2) cycle();
      chk("bp_full",  32'(full0), 32'h1);
      chk("bp_count", 32'(cnt0),  32'(DEPTH));
      chk("bp_ovf",   32'(of0),   32'h1);
      out_ready = 1'b1;
      repeat (DEPTH + 4) cycle();
      chk("drained", 32'(cnt0), 32'h0);

      // frame boundary
      do_clr();
      fd_seen = 0;
      for (int i = 0; i < LATENT_N - 1; i++) pair(DATA_W'(i), 16'hFC9C);
      cycle();
      chk("frame_pre", 32'(fd_seen), 32'h0);
      pair(DATA_W'(LATENT_N - 1), 16'hFC9C);
      cycle();
      chk("frame_hit", 32'(fd_seen), 32'h1);
      pair(DATA_W'(LATENT_N), 16'hFC9C);
      repeat (3) cycle();
      chk("frame_post", 32'(fd_seen), 32'h1);

      // reset mid-pair, with a done fall coincident with reset
      do_clr();
      capture(16'h0100, 1'b0, 1);
      done = 1'b1;
      cycle();
      done = 1'b0; op_mode = 1'b1; result = 16'h0200; rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();
      chk("rst_mid_seq", 32'(se0),  32'h0);
      capture(16'h0200, 1'b1, 1);
      cycle();
      chk("rst_var_seq",   32'(se0),  32'h1);
      chk("rst_var_count", 32'(cnt0), 32'h0);

      // clear with entries queued
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) pair(DATA_W'(i + 1), DATA_W'(i + 10));
      cycle();
      chk("pre_clr_count", 32'(cnt0), 32'h5);
      do_clr();
      chk("clr_count", 32'(cnt0), 32'h0);
      chk("clr_valid", 32'(ov0),  32'h0);
      repeat (2) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
